// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: splits one vector op into LANES scalar beats on the data-memory port.
// Optional ack timeout is enabled by defining VMEM_TIMEOUT_EN.
module vec_mem_sequencer #(
   parameter int LANES       = 4,
   parameter int DW          = 32,
   parameter int AW          = 10,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid,
   output logic                issue_ready,
   input  logic                op_load,
   input  logic                op_store,
   input  logic [AW-1:0]       base_addr,
   input  logic [9:0]          offset,
   input  logic [LANES*DW-1:0] st_data,
   input  logic [4:0]          dst_reg,
   output logic                mem_req,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic                mem_ack,
   input  logic [DW-1:0]       mem_rdata,
   output logic                wb_valid,
   output logic [4:0]          wb_reg,
   output logic [LANES*DW-1:0] wb_data,
   output logic                done,
   output logic                err
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic                load_q, load_d;
   logic [AW-1:0]       addr0_q, addr0_d;
   logic [LANES*DW-1:0] sdata_q, sdata_d;
   logic [4:0]          dst_q, dst_d;
   logic [LANES*DW-1:0] rbuf_q, rbuf_d;
   logic [4:0]          wb_reg_q, wb_reg_d;
   logic [LANES*DW-1:0] wb_data_q, wb_data_d;

`ifdef VMEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      // NOTE: every next-state variable gets a default first, so no path leaves one unassigned (no latches).
      state_d   = state_q;
      lane_d    = lane_q;
      load_d    = load_q;
      addr0_d   = addr0_q;
      sdata_d   = sdata_q;
      dst_d     = dst_q;
      rbuf_d    = rbuf_q;
      wb_reg_d  = wb_reg_q;
      wb_data_d = wb_data_q;
`ifdef VMEM_TIMEOUT_EN
      tmo_d     = tmo_q;
      err_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (issue_valid && (op_load || op_store)) begin
               state_d = S_REQ;
               lane_d  = '0;
               load_d  = op_load;
               addr0_d = base_addr + AW'(offset);
               sdata_d = st_data;
               dst_d   = dst_reg;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               // NOTE: rbuf_d is written then read below within this block; blocking order is intended here.
               if (load_q) rbuf_d[lane_q*DW +: DW] = mem_rdata;
               if (lane_q == LW'(LANES - 1)) begin
                  state_d = S_FIN;
                  if (load_q) begin
                     wb_data_d = rbuf_d;
                     wb_reg_d  = dst_q;
                  end
               end else begin
                  lane_d = lane_q + LW'(1);
               end
`ifdef VMEM_TIMEOUT_EN
               tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d = S_IDLE;
               lane_d  = '0;
               tmo_d   = '0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
`endif
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            lane_d  = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset clears the readback buffer too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lane_q    <= '0;
         load_q    <= 1'b0;
         addr0_q   <= '0;
         sdata_q   <= '0;
         dst_q     <= '0;
         rbuf_q    <= '0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         load_q    <= load_d;
         addr0_q   <= addr0_d;
         sdata_q   <= sdata_d;
         dst_q     <= dst_d;
         rbuf_q    <= rbuf_d;
         wb_reg_q  <= wb_reg_d;
         wb_data_q <= wb_data_d;
      end
   end

`ifdef VMEM_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYC;
   assign err        = 1'b0;
`endif

   // Beat outputs are zero outside REQ so an idle port shows the reset values.
   assign issue_ready = (state_q == S_IDLE);
   assign mem_req     = (state_q == S_REQ);
   assign mem_we      = mem_req & ~load_q;
   assign mem_addr    = mem_req ? (addr0_q + AW'(lane_q)) : '0;
   assign mem_wdata   = mem_req ? sdata_q[lane_q*DW +: DW] : '0;
   assign done        = (state_q == S_FIN);
   assign wb_valid    = done & load_q;
   assign wb_reg      = wb_reg_q;
   assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer (LANES=4, DW=32, AW=10).
// Covers the timeout path as well when built with VMEM_TIMEOUT_EN.
module tb_vec_mem_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         issue_valid, issue_ready, op_load, op_store;
   logic [9:0]   base_addr, offset;
   logic [127:0] st_data;
   logic [4:0]   dst_reg;
   logic         mem_req, mem_we, mem_ack;
   logic [9:0]   mem_addr;
   logic [31:0]  mem_wdata, mem_rdata;
   logic         wb_valid, done, err;
   logic [4:0]   wb_reg;
   logic [127:0] wb_data;

   int checks   = 0;
   int failures = 0;

   vec_mem_sequencer #(.LANES(4), .DW(32), .AW(10), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .op_load(op_load), .op_store(op_store),
      .base_addr(base_addr), .offset(offset), .st_data(st_data), .dst_reg(dst_reg),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serves the 4 beats of an op, acking each beat after dly idle cycles.
   task automatic beats(input logic is_store, input logic [9:0] a0, input int dly,
                        input logic [127:0] vec);
      logic [9:0] ea;
      for (int i = 0; i < 4; i++) begin
         ea = a0 + 10'(i);
         chk("beat_req", mem_req, 1'b1);
         chk("beat_addr", mem_addr, ea);
         chk("beat_we", mem_we, is_store);
         chk("beat_busy", issue_ready, 1'b0);
         if (is_store) chk("beat_wdata", mem_wdata, vec[i*32 +: 32]);
         for (int d = 0; d < dly; d++) begin
            mem_ack = 1'b0;
            step();
            chk("hold_req", mem_req, 1'b1);
            chk("hold_addr", mem_addr, ea);
            chk("hold_busy", issue_ready, 1'b0);
            if (is_store) chk("hold_wdata", mem_wdata, vec[i*32 +: 32]);
         end
         mem_ack   = 1'b1;
         mem_rdata = is_store ? 32'hDEAD_0000 : vec[i*32 +: 32];
         step();
         mem_ack   = 1'b0;
      end
   endtask

   localparam logic [127:0] RD1 = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
   localparam logic [127:0] SD  = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
   localparam logic [127:0] RD3 = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_FFFF};
   localparam logic [127:0] RD5 = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};

   int req_cnt;

   initial begin
      rst = 1'b1; issue_valid = 0; op_load = 0; op_store = 0;
      base_addr = '0; offset = '0; st_data = '0; dst_reg = '0; mem_ack = 0; mem_rdata = '0;
      step();
      chk("rst_ready", issue_ready, 1'b1);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 10'h000);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wbv", wb_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_wbdata", wb_data, 128'h0);
      rst = 1'b0;
      step();

      // 1: load, same-cycle acks
      issue_valid = 1; op_load = 1; base_addr = 10'h010; offset = 10'h004; dst_reg = 5'd7;
      step();
      issue_valid = 0; op_load = 0;
      beats(1'b0, 10'h014, 0, RD1);
      chk("t1_done", done, 1'b1);
      chk("t1_wbv", wb_valid, 1'b1);
      chk("t1_req_low", mem_req, 1'b0);
      chk("t1_wbreg", wb_reg, 5'd7);
      chk("t1_wbdata", wb_data, RD1);
      chk("t1_fin_busy", issue_ready, 1'b0);
      step();
      chk("t1_done_pulse", done, 1'b0);
      chk("t1_wbv_pulse", wb_valid, 1'b0);
      chk("t1_ready", issue_ready, 1'b1);
      chk("t1_wbdata_hold", wb_data, RD1);

      // 2: store, ack two cycles late on every beat
      issue_valid = 1; op_store = 1; base_addr = 10'h100; offset = 10'h000; st_data = SD; dst_reg = 5'd9;
      step();
      issue_valid = 0; op_store = 0; st_data = '0;
      beats(1'b1, 10'h100, 2, SD);
      chk("t2_done", done, 1'b1);
      chk("t2_wbv", wb_valid, 1'b0);
      chk("t2_wbdata_kept", wb_data, RD1);
      chk("t2_wbreg_kept", wb_reg, 5'd7);
      step();
      chk("t2_ready", issue_ready, 1'b1);

      // 3+4: wrapping load with both op bits set and issue_valid held throughout
      issue_valid = 1; op_load = 1; op_store = 1; base_addr = 10'h3FE; offset = 10'h001; dst_reg = 5'd3;
      step();
      beats(1'b0, 10'h3FF, 0, RD3);
      chk("t3_done", done, 1'b1);
      chk("t3_fin_busy", issue_ready, 1'b0);
      chk("t3_wbdata", wb_data, RD3);
      chk("t3_wbreg", wb_reg, 5'd3);
      step();
      chk("t4_ready", issue_ready, 1'b1);
      issue_valid = 0; op_load = 0; op_store = 0;
      mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
      step();
      step();
      mem_ack = 0;
      chk("t4_stray_req", mem_req, 1'b0);
      chk("t4_stray_ready", issue_ready, 1'b1);
      chk("t4_stray_done", done, 1'b0);
      chk("t4_stray_wbdata", wb_data, RD3);
      issue_valid = 1;
      step();
      issue_valid = 0;
      chk("t4_noop_ready", issue_ready, 1'b1);
      chk("t4_noop_req", mem_req, 1'b0);
      chk("t4_noop_done", done, 1'b0);

      // 5: reset during beat 2 of a load
      issue_valid = 1; op_load = 1; base_addr = 10'h200; offset = 10'h000; dst_reg = 5'd12;
      step();
      issue_valid = 0; op_load = 0;
      mem_ack = 1; mem_rdata = 32'h1234_0000; step();
      mem_rdata = 32'h1234_0001; step();
      mem_ack = 0;
      chk("t5_beat2_addr", mem_addr, 10'h202);
      rst = 1'b1;
      #1;
      chk("t5_rst_req", mem_req, 1'b0);
      chk("t5_rst_addr", mem_addr, 10'h000);
      chk("t5_rst_ready", issue_ready, 1'b1);
      chk("t5_rst_wbdata", wb_data, 128'h0);
      chk("t5_rst_wbreg", wb_reg, 5'd0);
      step();
      chk("t5_no_done", done, 1'b0);
      chk("t5_no_wbv", wb_valid, 1'b0);
      rst = 1'b0;
      step();
      issue_valid = 1; op_load = 1; base_addr = 10'h020; offset = 10'h003; dst_reg = 5'd21;
      step();
      issue_valid = 0; op_load = 0;
      beats(1'b0, 10'h023, 0, RD5);
      chk("t5_done", done, 1'b1);
      chk("t5_wbv", wb_valid, 1'b1);
      chk("t5_wbdata", wb_data, RD5);
      chk("t5_wbreg", wb_reg, 5'd21);
      step();

      // 6: load that is never acked
      issue_valid = 1; op_load = 1; base_addr = 10'h040; offset = 10'h000; dst_reg = 5'd1;
      step();
      issue_valid = 0; op_load = 0;
`ifdef VMEM_TIMEOUT_EN
      req_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (mem_req === 1'b1 && err === 1'b0) req_cnt++;
         step();
      end
      chk("t6_req_cycles", req_cnt, 16);
      chk("t6_err", err, 1'b1);
      chk("t6_req_fall", mem_req, 1'b0);
      chk("t6_ready", issue_ready, 1'b1);
      chk("t6_no_done", done, 1'b0);
      chk("t6_no_wbv", wb_valid, 1'b0);
      chk("t6_wbdata_kept", wb_data, RD5);
      step();
      chk("t6_err_pulse", err, 1'b0);
`else
      req_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req === 1'b1 && mem_addr === 10'h040) req_cnt++;
         step();
      end
      chk("t6_req_stuck", req_cnt, 40);
      chk("t6_err_zero", err, 1'b0);
      chk("t6_busy", issue_ready, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("t6_recover", issue_ready, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
